// File: rtl/result_collector_slave_if.sv
// result_collector_slave_if
//   Drain side of the array result path. Each beat on the four south-edge
//   result lanes is packed into one word and pushed into a circular FIFO.
//   When a full frame has been buffered the array is held off and the host
//   reads the frame back one word per accepted read.
//
// Ports
//   clk, resetn           clock (posedge) and asynchronous active-low reset
//   s1_data..s4_data      result lanes, packed as {s4,s3,s2,s1}
//   res_valid/res_ready   beat handshake from the array
//   host_re               host read request, honoured only while draining
//   host_data/host_valid  registered read data and its 1-cycle valid pulse
//   fifo_full/fifo_empty  occupancy flags
//   word_count            current occupancy
//   frame_ready           a complete frame is buffered (drain state)
//   frame_done            pulse alongside the last word of a frame
//   drop_err              sticky: a beat was offered while not ready
module result_collector_slave_if #(
  parameter int LANE_W      = 8,
  parameter int W           = 32,
  parameter int D           = 8,
  parameter int FRAME_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [LANE_W-1:0]    s1_data,
  input  logic [LANE_W-1:0]    s2_data,
  input  logic [LANE_W-1:0]    s3_data,
  input  logic [LANE_W-1:0]    s4_data,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic                 host_re,
  output logic [W-1:0]         host_data,
  output logic                 host_valid,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic [$clog2(D):0]   word_count,
  output logic                 frame_ready,
  output logic                 frame_done,
  output logic                 drop_err
);

  localparam int NUM_LANES = 4;
  localparam int AW        = $clog2(D);
  localparam int PW        = AW + 1;
  localparam int FW        = $clog2(FRAME_WORDS + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                           state, state_nxt;
  logic [FW-1:0]                    fcnt, fcnt_nxt;
  logic [PW-1:0]                    wptr, rptr;
  logic [W-1:0]                     mem [D];
  logic [NUM_LANES-1:0][LANE_W-1:0] lane;
  logic                             accept, rd, last_rd;

  // Lane 1 lands in the least significant byte.
  assign lane[0] = s1_data;
  assign lane[1] = s2_data;
  assign lane[2] = s3_data;
  assign lane[3] = s4_data;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign word_count  = wptr - rptr;
  assign fifo_empty  = (wptr == rptr);
  assign fifo_full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign frame_ready = (state == DRAIN);
  assign res_ready   = (state != DRAIN) && !fifo_full;
  assign accept      = res_valid && res_ready;
  assign rd          = host_re && (state == DRAIN) && !fifo_empty;

  // Storage is not reset; pointers alone define what is reachable.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr[AW-1:0]] <= lane;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr       <= '0;
      rptr       <= '0;
      host_data  <= '0;
      host_valid <= 1'b0;
      frame_done <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      if (accept) wptr <= wptr + PW'(1);
      if (rd) begin
        rptr      <= rptr + PW'(1);
        host_data <= mem[rptr[AW-1:0]];
      end
      host_valid <= rd;
      frame_done <= last_rd;
      if (res_valid && !res_ready) drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    last_rd   = 1'b0;
    case (state)
      IDLE: begin
        fcnt_nxt = '0;
        if (accept) begin
          fcnt_nxt  = FW'(1);
          state_nxt = (FRAME_WORDS == 1) ? DRAIN : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          fcnt_nxt = fcnt + FW'(1);
          if (fcnt + FW'(1) == FW'(FRAME_WORDS)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // The read that empties the FIFO closes the frame.
        if (rd && word_count == PW'(1)) begin
          state_nxt = IDLE;
          fcnt_nxt  = '0;
          last_rd   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        fcnt_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_result_collector_slave_if.sv
module tb_result_collector_slave_if;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  // Default instance: D=8, FRAME_WORDS=8
  logic [7:0]  s1, s2, s3, s4;
  logic        res_valid, host_re;
  logic        res_ready, host_valid, fifo_full, fifo_empty;
  logic        frame_ready, frame_done, drop_err;
  logic [31:0] host_data;
  logic [3:0]  word_count;

  // Short-frame instance: D=8, FRAME_WORDS=3
  logic [7:0]  b_s1, b_s2, b_s3, b_s4;
  logic        b_res_valid, b_host_re;
  logic        b_res_ready, b_host_valid, b_fifo_full, b_fifo_empty;
  logic        b_frame_ready, b_frame_done, b_drop_err;
  logic [31:0] b_host_data;
  logic [3:0]  b_word_count;

  result_collector_slave_if dut (
    .clk(clk), .resetn(resetn),
    .s1_data(s1), .s2_data(s2), .s3_data(s3), .s4_data(s4),
    .res_valid(res_valid), .res_ready(res_ready), .host_re(host_re),
    .host_data(host_data), .host_valid(host_valid),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .word_count(word_count),
    .frame_ready(frame_ready), .frame_done(frame_done), .drop_err(drop_err)
  );

  result_collector_slave_if #(.LANE_W(8), .W(32), .D(8), .FRAME_WORDS(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .s1_data(b_s1), .s2_data(b_s2), .s3_data(b_s3), .s4_data(b_s4),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .host_re(b_host_re),
    .host_data(b_host_data), .host_valid(b_host_valid),
    .fifo_full(b_fifo_full), .fifo_empty(b_fifo_empty), .word_count(b_word_count),
    .frame_ready(b_frame_ready), .frame_done(b_frame_done), .drop_err(b_drop_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [7:0] k);
    return {8'(k + 8'd3), 8'(k + 8'd2), 8'(k + 8'd1), k};
  endfunction

  task automatic push(input logic [7:0] k);
    @(negedge clk);
    s1 = k; s2 = 8'(k + 8'd1); s3 = 8'(k + 8'd2); s4 = 8'(k + 8'd3);
    res_valid = 1'b1;
  endtask

  task automatic push_b(input logic [7:0] k);
    @(negedge clk);
    b_s1 = k; b_s2 = 8'(k + 8'd1); b_s3 = 8'(k + 8'd2); b_s4 = 8'(k + 8'd3);
    b_res_valid = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s1 = '0; s2 = '0; s3 = '0; s4 = '0; res_valid = 0; host_re = 0;
    b_s1 = '0; b_s2 = '0; b_s3 = '0; b_s4 = '0; b_res_valid = 0; b_host_re = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;

    // T1: reset mid-stream
    push(8'hA0); push(8'hA4); push(8'hA8);
    @(negedge clk);
    res_valid = 1'b0;
    chk("t1_pre_count", 32'(word_count), 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("t1_res_ready", 32'(res_ready), 32'd1);
    chk("t1_empty", 32'(fifo_empty), 32'd1);
    chk("t1_full", 32'(fifo_full), 32'd0);
    chk("t1_count", 32'(word_count), 32'd0);
    chk("t1_frame_ready", 32'(frame_ready), 32'd0);
    chk("t1_host_valid", 32'(host_valid), 32'd0);
    chk("t1_drop_err", 32'(drop_err), 32'd0);
    chk("t1_host_data", host_data, 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    // T2: fill one frame
    for (int j = 0; j < 8; j++) push(8'(4 * j));
    @(negedge clk);
    chk("t2_frame_ready", 32'(frame_ready), 32'd1);
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_count", 32'(word_count), 32'd8);
    chk("t2_res_ready", 32'(res_ready), 32'd0);
    chk("t2_drop_err", 32'(drop_err), 32'd0);

    // T4a: beat offered during drain is dropped
    @(negedge clk);
    res_valid = 1'b0;
    chk("t4_drop_err", 32'(drop_err), 32'd1);
    chk("t4_count", 32'(word_count), 32'd8);

    // T3: drain
    host_re = 1'b1;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 7) host_re = 1'b0;
      chk("t3_valid", 32'(host_valid), 32'd1);
      chk("t3_data", host_data, word(8'(4 * j)));
      chk("t3_done", 32'(frame_done), (j == 7) ? 32'd1 : 32'd0);
    end
    chk("t3_last_word", host_data, 32'h1F1E1D1C);
    chk("t3_res_ready", 32'(res_ready), 32'd1);
    chk("t3_empty", 32'(fifo_empty), 32'd1);
    chk("t3_frame_ready", 32'(frame_ready), 32'd0);
    @(negedge clk);
    chk("t3_done_off", 32'(frame_done), 32'd0);
    chk("t3_valid_off", 32'(host_valid), 32'd0);

    // T4b: host read while idle is ignored
    host_re = 1'b1;
    @(negedge clk);
    host_re = 1'b0;
    chk("t4_idle_valid", 32'(host_valid), 32'd0);
    chk("t4_idle_hold", host_data, 32'h1F1E1D1C);
    chk("t4_idle_count", 32'(word_count), 32'd0);
    chk("t4_sticky", 32'(drop_err), 32'd1);

    // T5: reset after three reads, then a fresh frame
    for (int j = 0; j < 8; j++) push(8'(8'hC0 + 4 * j));
    @(negedge clk);
    res_valid = 1'b0;
    host_re = 1'b1;
    repeat (3) @(negedge clk);
    host_re = 1'b0;
    chk("t5_mid_count", 32'(word_count), 32'd5);
    chk("t5_mid_data", host_data, 32'hCBCAC9C8);
    resetn = 1'b0;
    #1;
    @(negedge clk);
    resetn = 1'b1;
    chk("t5_drop_err", 32'(drop_err), 32'd0);
    chk("t5_empty", 32'(fifo_empty), 32'd1);
    chk("t5_frame_ready", 32'(frame_ready), 32'd0);
    for (int j = 0; j < 8; j++) push(8'(100 + 4 * j));
    @(negedge clk);
    res_valid = 1'b0;
    host_re = 1'b1;
    chk("t5_full", 32'(fifo_full), 32'd1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 7) host_re = 1'b0;
      if (j == 0) chk("t5_first", host_data, 32'h67666564);
      chk("t5_data", host_data, word(8'(100 + 4 * j)));
      chk("t5_done", 32'(frame_done), (j == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t5_empty_end", 32'(fifo_empty), 32'd1);

    // T6: three-word frames, three times round (addresses wrap past 7)
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 3; j++) push_b(8'(40 * f + 4 * j));
      @(negedge clk);
      b_res_valid = 1'b0;
      chk("t6_frame_ready", 32'(b_frame_ready), 32'd1);
      chk("t6_count", 32'(b_word_count), 32'd3);
      chk("t6_res_ready", 32'(b_res_ready), 32'd0);
      chk("t6_full", 32'(b_fifo_full), 32'd0);
      b_host_re = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if (j == 2) b_host_re = 1'b0;
        chk("t6_valid", 32'(b_host_valid), 32'd1);
        chk("t6_data", b_host_data, word(8'(40 * f + 4 * j)));
        chk("t6_done", 32'(b_frame_done), (j == 2) ? 32'd1 : 32'd0);
      end
      chk("t6_empty", 32'(b_fifo_empty), 32'd1);
      chk("t6_idle", 32'(b_frame_ready), 32'd0);
    end
    chk("t6_drop_err", 32'(b_drop_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
